// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam digit_t CODE_MINUS = 4'hA;

endpackage

// File: rtl/seg_decode.sv
// Combinational digit-code to segment-pattern lookup.
// Codes 0-9 are numerals, CODE_MINUS is a minus sign, everything else is blank.
module seg_decode
  import seg_pkg::*;
(
  input  digit_t     code,
  output logic [6:0] seg
);

  // Map one digit code onto its active-low segment pattern
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      CODE_MINUS: seg = SEG_MINUS;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A frame snapshot is scanned one digit per slot; each slot opens with a
// dead-time gap where every digit is dark, to keep adjacent digits from ghosting.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int CLK_DIV  = 50000,
  parameter int DEAD     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_lzb,
  input  logic [4*N_DIGITS-1:0] i_data,
  input  logic [N_DIGITS-1:0]   i_dp,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [N_DIGITS-1:0]   o_dig
);

  localparam int PCNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLK_DIV - 1);
  localparam logic [PCNT_W-1:0] DEAD_END  = PCNT_W'(DEAD);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [PCNT_W-1:0]     pcnt;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  logic                  frame_end;
  logic                  on;

  logic [4*N_DIGITS-1:0] data_s;
  logic [N_DIGITS-1:0]   dp_s;
  logic                  lzb_s;

  logic [N_DIGITS-1:0]   blank;
  logic                  zero_run;
  digit_t                sel_code;
  logic                  sel_blank;
  logic                  sel_dp;
  logic [6:0]            dec_seg;

  logic [N_DIGITS-1:0]   dig_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  assign tick      = (pcnt == PCNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);
  assign on        = i_en && (pcnt >= DEAD_END);

  // Slot prescaler: free-runs 0..CLK_DIV-1 regardless of the enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Digit index advances once per slot and wraps after the top digit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx <= '0;
    end else if (tick) begin
      if (idx == IDX_LAST) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Frame snapshot taken at the end of the last slot so a frame never tears
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_s <= '0;
      dp_s   <= '0;
      lzb_s  <= 1'b0;
    end else if (frame_end) begin
      data_s <= i_data;
      dp_s   <= i_dp;
      lzb_s  <= i_lzb;
    end
  end

  // Leading-zero blanking: walk down from the top digit while codes stay zero
  always_comb begin
    blank    = '0;
    zero_run = lzb_s;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (data_s[4*k +: 4] == 4'h0);
      blank[k] = zero_run;
    end
  end

  // Pick the code, blank flag and decimal point of the digit being scanned
  always_comb begin
    sel_code  = '0;
    sel_blank = 1'b0;
    sel_dp    = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_code  = data_s[4*k +: 4];
        sel_blank = blank[k];
        sel_dp    = dp_s[k];
      end
    end
  end

  seg_decode u_decode (
    .code (sel_code),
    .seg  (dec_seg)
  );

  // Next display state: one digit low while lit, everything dark otherwise
  always_comb begin
    dig_next = '1;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (on) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        dig_next[k] = (idx != IDX_W'(k));
      end
      seg_next = sel_blank ? SEG_BLANK : dec_seg;
      dp_next  = ~sel_dp;
    end
  end

  // Output registers so the pins change only on clock edges, dark on reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dig <= '1;
      o_seg <= SEG_BLANK;
      o_dp  <= 1'b1;
    end else begin
      o_dig <= dig_next;
      o_seg <= seg_next;
      o_dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with N_DIGITS=4, CLK_DIV=4, DEAD=1.
// The stimulus pushes the hand-derived expected pattern of every slot; the
// monitor pops one entry each time a digit lights up and checks dark cycles.
module tb_seg_scan_driver;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_en = 1'b0;
  logic        i_lzb = 1'b0;
  logic [15:0] i_data = '0;
  logic [3:0]  i_dp = '0;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_dig;

  slot_t exp_q[$];
  slot_t cur_exp;
  int    vectors = 0;
  int    miscompares = 0;
  int    e = 0;
  int    run_len = 0;
  bit    mon_en = 1'b0;
  bit    check_runs = 1'b0;
  logic [3:0] prev_dig = 4'hF;

  seg_scan_driver #(
    .N_DIGITS (4),
    .CLK_DIV  (4),
    .DEAD     (1)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_lzb   (i_lzb),
    .i_data  (i_data),
    .i_dp    (i_dp),
    .o_seg   (o_seg),
    .o_dp    (o_dp),
    .o_dig   (o_dig)
  );

  // Free-running 100 MHz clock
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [11:0] actual,
                             input logic [11:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %03h, expected %03h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp, input logic lzb);
    i_data = data;
    i_dp   = dp;
    i_lzb  = lzb;
  endtask

  task automatic pushSlot(input logic [3:0] dig, input logic [6:0] seg, input logic dp);
    exp_q.push_back({dig, seg, dp});
  endtask

  task automatic pushFrame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [3:0] dp_n);
    pushSlot(4'hE, s0, dp_n[0]);
    pushSlot(4'hD, s1, dp_n[1]);
    pushSlot(4'hB, s2, dp_n[2]);
    pushSlot(4'h7, s3, dp_n[3]);
  endtask

  task automatic gotoEdge(input int target);
    repeat (target - e) @(negedge i_clk);
    e = target;
  endtask

  // Monitor: pop on each newly lit digit, hold it stable, keep dark cycles dark
  initial begin
    forever begin
      @(negedge i_clk);
      if (mon_en) begin
        vectors++;
        if (!(o_dig inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
          miscompares++;
          $display("[TB] FAIL dig_onehot at %0t: got %h, expected one low bit or F", $time, o_dig);
        end
        if (o_dig == 4'hF) begin
          checkOutput("dark_segments", {4'h0, o_seg, o_dp}, {4'h0, 7'h7F, 1'b1});
          if (prev_dig != 4'hF && check_runs)
            checkOutput("lit_run_len", 12'(run_len), 12'd3);
          run_len = 0;
        end else begin
          run_len++;
          if (prev_dig == 4'hF) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("[TB] FAIL slot_output at %0t: got %h/%h/%b, expected no lit digit",
                       $time, o_dig, o_seg, o_dp);
            end else begin
              cur_exp = exp_q.pop_front();
              checkOutput("slot_output", {o_dig, o_seg, o_dp}, cur_exp);
            end
          end else begin
            checkOutput("slot_hold", {o_dig, o_seg, o_dp}, cur_exp);
          end
        end
        prev_dig = o_dig;
      end
    end
  end

  // Watchdog so a stuck run still ends with a report
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expected frames
  initial begin
    #1 i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    checkOutput("reset_state", {o_dig, o_seg, o_dp}, {4'hF, 7'h7F, 1'b1});

    $display("[TB] release reset, first frame shows zeros, 1234h latched at its end");
    applyStimulus(16'h1234, 4'b0100, 1'b0);
    i_en = 1'b1;
    pushFrame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
    pushFrame(7'h19, 7'h30, 7'h24, 7'h79, 4'b1011);
    pushFrame(7'h19, 7'h30, 7'h24, 7'h79, 4'b1011);
    mon_en = 1'b1;
    check_runs = 1'b1;
    i_rst_n = 1'b1;
    e = 0;
    gotoEdge(1);
    checkOutput("first_dead", {8'h0, o_dig}, {8'h0, 4'hF});
    gotoEdge(2);
    checkOutput("first_lit", {o_dig, o_seg, o_dp}, {4'hE, 7'h40, 1'b1});

    $display("[TB] mid-frame change to 5678h");
    gotoEdge(42);
    applyStimulus(16'h5678, 4'b0100, 1'b0);
    pushFrame(7'h00, 7'h78, 7'h02, 7'h12, 4'b1011);

    $display("[TB] 0070h with leading-zero blanking");
    gotoEdge(50);
    applyStimulus(16'h0070, 4'b0100, 1'b1);
    pushFrame(7'h40, 7'h78, 7'h7F, 7'h7F, 4'b1011);

    gotoEdge(66);
    applyStimulus(16'h0070, 4'b0100, 1'b0);
    pushFrame(7'h40, 7'h78, 7'h40, 7'h40, 4'b1011);

    $display("[TB] FA0Bh blank and minus codes");
    gotoEdge(82);
    applyStimulus(16'hFA0B, 4'b0100, 1'b0);
    pushFrame(7'h7F, 7'h40, 7'h3F, 7'h7F, 4'b1011);
    pushSlot(4'hE, 7'h7F, 1'b1);
    pushSlot(4'hD, 7'h40, 1'b1);
    pushSlot(4'hB, 7'h3F, 1'b0);

    $display("[TB] asynchronous reset in slot 2");
    gotoEdge(122);
    check_runs = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 checkOutput("async_reset_off", {o_dig, o_seg, o_dp}, {4'hF, 7'h7F, 1'b1});
    repeat (3) @(negedge i_clk);
    pushFrame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
    pushFrame(7'h7F, 7'h40, 7'h3F, 7'h7F, 4'b1011);
    i_rst_n = 1'b1;
    e = 0;
    check_runs = 1'b1;
    gotoEdge(1);
    checkOutput("restart_dead", {8'h0, o_dig}, {8'h0, 4'hF});
    gotoEdge(2);
    checkOutput("restart_slot0", {o_dig, o_seg, o_dp}, {4'hE, 7'h40, 1'b1});

    $display("[TB] enable pulse low for three cycles");
    gotoEdge(18);
    check_runs = 1'b0;
    i_en = 1'b0;
    #1 checkOutput("en_drop_delay", {8'h0, o_dig}, {8'h0, 4'hE});
    gotoEdge(19);
    checkOutput("en_off", {o_dig, o_seg, o_dp}, {4'hF, 7'h7F, 1'b1});
    gotoEdge(21);
    i_en = 1'b1;
    check_runs = 1'b1;
    gotoEdge(22);
    checkOutput("resume_phase", {o_dig, o_seg, o_dp}, {4'hD, 7'h40, 1'b1});

    gotoEdge(33);
    checkOutput("queue_drained", 12'(exp_q.size()), 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
